inv_sub_bytes_iter: RTL
=======================

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 1, meaning inverse S-box lookups per cycle; legal values are 1, 2, 4 and 16.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning state_in holds a valid state.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block can accept a state.
REQ-006 SHALL have port state_in, input, 128 bits, meaning the AES state; byte i is state_in[8i+7:8i].
REQ-007 SHALL have port out_valid, output, 1 bit, meaning state_out holds a result.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-009 SHALL have port state_out, output, 128 bits, meaning the InvSubBytes result of the accepted state.
REQ-010 SHALL have port chk_err, output, 1 bit, meaning a self-check mismatch is sticky until the next accept.

Function
REQ-011 SHALL implement the FIPS-197 inverse S-box as an internal constant table, instantiated BYTES_PER_CYCLE times.
REQ-012 SHALL run FSM states IDLE, BUSY and DONE.
- IDLE: in_ready=1. On in_valid&&in_ready it captures state_in into the working register, clears the byte counter and chk_err, and moves to BUSY.
REQ-013 SHALL, in BUSY, replace bytes cnt..cnt+BYTES_PER_CYCLE-1 with their inverse S-box values each cycle and advance cnt by BYTES_PER_CYCLE.
- Byte 0 is processed first.
- Untouched bytes hold their value.
REQ-014 SHALL move BUSY->DONE on the cycle that processes byte 15, where N=16/BYTES_PER_CYCLE.
- out_valid rises exactly N cycles after the accepting edge.
- The counter does not wrap past 15.
REQ-015 SHALL, in DONE, hold out_valid=1 and keep state_out stable until out_valid&&out_ready, then return to IDLE.
REQ-016 SHALL keep in_ready=0 in BUSY and DONE; there is no overlap, so a new accept is possible only from the cycle after the handshake.
REQ-017 SHALL drive state_out directly from the working register, so intermediate values are visible but qualified only by out_valid.
REQ-018 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-019 SHALL, while rst_n=0 at a clock edge, force state IDLE, cnt=0, working register=0, out_valid=0, in_ready=1 after reset and chk_err=0.
REQ-020 SHALL abort any BUSY or DONE operation when reset is applied; the in-flight result is discarded and never presented.
REQ-021 SHALL keep in_ready=0 during the reset cycle, so no accept occurs while rst_n=0.

Configuration
REQ-022 SHALL, with macro INV_SBOX_SELFCHECK_EN defined, add forward S-box tables that re-encrypt each processed byte in the same cycle.
- The re-encrypted byte is compared with the original captured byte.
- Any mismatch sets chk_err, which holds until the next accept or reset.
REQ-023 SHALL, without INV_SBOX_SELFCHECK_EN, omit the forward tables and the comparison, tie chk_err to 0, and leave timing identical.

Verification
REQ-024 SHALL pass this scenario: BYTES_PER_CYCLE=1, state_in=128'h63636363_63636363_63636363_63636363 -> out_valid exactly 16 cycles after accept, state_out=128'h0, chk_err=0.
REQ-025 SHALL pass this scenario: state_in bytes [0]=8'h7C, [1]=8'hED, [2]=8'hFF, [3]=8'h76 with the rest 8'h63 -> state_out bytes 8'h01, 8'h53, 8'h7D, 8'h0F with the rest 8'h00.
REQ-026 SHALL pass this scenario: out_ready held 0 for 5 cycles in DONE -> out_valid and state_out stable; in_valid pulses are ignored with in_ready=0; the handshake on cycle 6 leads to IDLE on the next edge.
REQ-027 SHALL pass this scenario: rst_n=0 asserted at cnt=7 in BUSY -> after the edge, state IDLE, out_valid=0 and state_out=0; the following operation gives a correct result.
REQ-028 SHALL pass this scenario: BYTES_PER_CYCLE=4 and 16 -> latency 4 and 1 cycles respectively, with results identical to REQ-024 and REQ-025.
REQ-029 SHALL pass this scenario: with INV_SBOX_SELFCHECK_EN defined and all 256 byte values sent in 16 states -> each output equals the golden inverse table and chk_err stays 0.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE inverse S-box lanes walk the 16-byte state in place.
// Optional forward-S-box re-encryption self-check enabled by defining INV_SBOX_SELFCHECK_EN.
`timescale 1ns/1ps
module inv_sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         chk_err
);

    localparam int unsigned NBYTES   = 16;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned LAST_CNT = NBYTES - BYTES_PER_CYCLE;

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic [STATE_W-1:0]             work_q;
    logic [STATE_W-1:0]             work_d;
    logic [STATE_W-1:0]             work_upd;
    logic [BYTES_PER_CYCLE-1:0][7:0] lane_in;
    logic [BYTES_PER_CYCLE-1:0][7:0] lane_out;
    logic                           busy;
    logic                           last;
    logic                           accept;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = BUSY;
            BUSY:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State-decoded outputs; in_ready is masked by rst_n so nothing is accepted during reset
    always_comb begin
        in_ready  = rst_n & (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY);
        last      = busy & (cnt_q == CNT_W'(LAST_CNT));
    end

    assign accept    = in_valid & in_ready;
    assign state_out = work_q;

    // Lookup lanes read the bytes at cnt..cnt+BYTES_PER_CYCLE-1
    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
        assign lane_in[k]  = work_q[{cnt_q + CNT_W'(k), 3'b000} +: 8];
        assign lane_out[k] = INV_SBOX[lane_in[k]];
    end

    // Each byte is owned by a fixed lane; it updates only when cnt reaches its group base
    for (genvar j = 0; j < NBYTES; j++) begin : g_byte
        localparam int unsigned LANE = j % BYTES_PER_CYCLE;
        localparam int unsigned BASE = j - LANE;
        assign work_upd[8*j +: 8] = (busy && (cnt_q == CNT_W'(BASE))) ? lane_out[LANE]
                                                                      : work_q[8*j +: 8];
    end

    always_comb begin
        work_d = work_upd;
        cnt_d  = cnt_q;
        if (accept) begin
            work_d = state_in;
            cnt_d  = '0;
        end else if (busy && !last) begin
            cnt_d  = cnt_q + CNT_W'(BYTES_PER_CYCLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef INV_SBOX_SELFCHECK_EN
    localparam logic [0:255][7:0] FWD_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [BYTES_PER_CYCLE-1:0] lane_bad;
    logic                       chk_err_q;

    // Lane input is still the captured byte, so re-encrypting the result must reproduce it
    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_chk
        assign lane_bad[k] = (FWD_SBOX[lane_out[k]] != lane_in[k]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (accept) begin
            chk_err_q <= 1'b0;
        end else if (busy && (|lane_bad)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
